// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 16-bit x 4096 memory.
// Optional MEM_ARB_LOCK_EN adds lock0/lock1 so a port can keep the memory across back-to-back accesses.
module mem_port_arbiter #(
  parameter int WORD    = 16,
  parameter int ADDRESS = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               we0,
  input  logic [ADDRESS-1:0] addr0,
  input  logic [WORD-1:0]    wdata0,
  output logic               ack0,
  input  logic               req1,
  input  logic               we1,
  input  logic [ADDRESS-1:0] addr1,
  input  logic [WORD-1:0]    wdata1,
  output logic               ack1,
`ifdef MEM_ARB_LOCK_EN
  input  logic               lock0,
  input  logic               lock1,
`endif
  output logic [WORD-1:0]    rdata,
  output logic               busy,
  output logic [ADDRESS-1:0] mem_address,
  output logic               mem_write_enable,
  output logic [WORD-1:0]    mem_write_data,
  input  logic [WORD-1:0]    mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [ADDRESS-1:0]   addr_reg;
  logic                 we_reg;
  logic [WORD-1:0]      wdata_reg;
  logic [WORD-1:0]      rdata_reg;
  logic                 grant_id;
  logic                 last_grant;

  logic                 take;
  logic                 grant_next;
  logic                 update_last;
  logic                 lock_hit;

`ifdef MEM_ARB_LOCK_EN
  logic                 lock_held;

  // The previous winner keeps the memory only while it still presents a request.
  assign lock_hit = lock_held && (grant_id ? req1 : req0);
`else
  assign lock_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    take        = 1'b0;
    grant_next  = 1'b0;
    update_last = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take       = 1'b1;
          state_next = ACCESS;
          if (lock_hit) begin
            grant_next = grant_id;
          end else begin
            grant_next  = (req0 && req1) ? ~last_grant : req1;
            update_last = 1'b1;
          end
        end
      end
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else if (take) begin
      addr_reg  <= grant_next ? addr1 : addr0;
      we_reg    <= grant_next ? we1 : we0;
      wdata_reg <= grant_next ? wdata1 : wdata0;
      grant_id  <= grant_next;
      if (update_last) begin
        last_grant <= grant_next;
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // An IDLE cycle without the locked port's request (or a fresh grant) re-evaluates the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_held <= 1'b0;
    end else if (state == IDLE) begin
      lock_held <= take ? (grant_next ? lock1 : lock0) : 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (state == ACCESS && !we_reg) begin
      rdata_reg <= mem_read_data;
    end
  end

  // Write enable is decoded from state so an asynchronous reset drops it at once.
  assign mem_write_enable = (state == ACCESS) && we_reg;
  assign mem_address      = addr_reg;
  assign mem_write_data   = wdata_reg;
  assign ack0             = (state == DONE) && !grant_id;
  assign ack1             = (state == DONE) && grant_id;
  assign busy             = (state != IDLE);
  assign rdata            = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single accesses plus reset,
// round-robin and lock sequences, with a scoreboard of expected acks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, mem_write_enable;
  logic [15:0] rdata, mem_write_data, mem_read_data;
  logic [11:0] mem_address;
`ifdef MEM_ARB_LOCK_EN
  logic        lock0 = 1'b0, lock1 = 1'b0;
`endif

  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [15:0] bd_data = '0;
  logic [15:0] mem [4096];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int we_cnt = 0;
  int ack_cycles[$];

  typedef struct {
    logic        port;
    logic [15:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        port;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t vecs[10];

  mem_port_arbiter #(.WORD(16), .ADDRESS(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
`ifdef MEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cycle, act, exp);
    end
  endtask

  // Every wait goes through here so each DONE cycle is scored exactly once.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cycle++;
    if (mem_write_enable) we_cnt++;
    if (ack0 && ack1) chk("ack_both", 1, 0);
    if (ack0 || ack1) begin
      ack_cycles.push_back(cycle);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {31'd0, ack1}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", {31'd0, ack1}, {31'd0, e.port});
        chk("ack_rdata", {16'd0, rdata}, {16'd0, e.rdata});
        $display("txn cycle=%0d port=%0d rdata=0x%04h", cycle, ack1, rdata);
      end
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ack0", {31'd0, ack0}, 0);
    chk("rst_ack1", {31'd0, ack1}, 0);
    chk("rst_rdata", {16'd0, rdata}, 0);
    chk("rst_mem_address", {20'd0, mem_address}, 0);
    chk("rst_mem_we", {31'd0, mem_write_enable}, 0);
    chk("rst_mem_wdata", {16'd0, mem_write_data}, 0);
  endtask

  task automatic do_access(input logic port, input logic we, input logic [11:0] a,
                           input logic [15:0] d, input logic [15:0] exp_rd);
    exp_t e;
    int   n;
    int   base;
    logic got;
    e.port = port; e.rdata = exp_rd;
    exp_q.push_back(e);
    if (!port) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else       begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    base = we_cnt;
    tick();
    n = 1;
    chk("access_busy", {31'd0, busy}, 1);
    chk("access_mem_we", {31'd0, mem_write_enable}, {31'd0, we});
    chk("access_mem_address", {20'd0, mem_address}, {20'd0, a});
    if (we) chk("access_mem_wdata", {16'd0, mem_write_data}, {16'd0, d});
    got = 1'b0;
    while (!got && n < 10) begin
      tick();
      n++;
      got = port ? ack1 : ack0;
    end
    chk("ack_latency", n, 2);
    chk("done_busy", {31'd0, busy}, 1);
    req0 = 1'b0; req1 = 1'b0;
    chk("we_pulses", we_cnt - base, {31'd0, we});
    tick();
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_mem_we", {31'd0, mem_write_enable}, 0);
  endtask

  initial begin
    exp_t e;
    int   stage;
    logic p0_done, p1_done;

    vecs[0] = '{1'b0, 1'b0, 12'h014, 16'h0000, 16'h0008};
    vecs[1] = '{1'b1, 1'b1, 12'h016, 16'h000A, 16'h0008};
    vecs[2] = '{1'b0, 1'b0, 12'h016, 16'h0000, 16'h000A};
    vecs[3] = '{1'b1, 1'b0, 12'h014, 16'h0000, 16'h0008};
    vecs[4] = '{1'b0, 1'b1, 12'hFFF, 16'hBEEF, 16'h0008};
    vecs[5] = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b1, 12'h000, 16'hFFFF, 16'hBEEF};
    vecs[7] = '{1'b1, 1'b0, 12'h000, 16'h0000, 16'hFFFF};
    vecs[8] = '{1'b1, 1'b1, 12'h016, 16'h1234, 16'hFFFF};
    vecs[9] = '{1'b0, 1'b0, 12'h016, 16'h0000, 16'h1234};

    do_reset();
    chk_reset_outputs();
    poke(12'h014, 16'h0008);

    for (int i = 0; i < 10; i++)
      do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    // Reset asserted in the middle of the ACCESS cycle of a write.
    poke(12'h058, 16'hCCCC);
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h058; wdata0 = 16'h5A5A;
    tick();
    chk("midrst_we_before", {31'd0, mem_write_enable}, 1);
    #1 rst_n = 1'b0;
    #1 chk("midrst_we_async", {31'd0, mem_write_enable}, 0);
    tick();
    chk_reset_outputs();
    req0 = 1'b0; we0 = 1'b0;
    rst_n = 1'b1;
    tick();
    do_access(1'b0, 1'b0, 12'h058, 16'h0000, 16'hCCCC);

    // Both ports requesting continuously: grants alternate starting with port 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e.port = i[0];
      e.rdata = i[0] ? 16'h1234 : 16'h0008;
      exp_q.push_back(e);
    end
    ack_cycles.delete();
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h014;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h016;
    for (int k = 0; k < 30 && ack_cycles.size() < 4; k++) tick();
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_ack_count", ack_cycles.size(), 4);
    for (int i = 1; i < ack_cycles.size(); i++)
      chk("rr_ack_spacing", ack_cycles[i] - ack_cycles[i-1], 3);
    tick();
    tick();
    tick();

    // Port 0 read-modify-write against a pending port-1 read.
    poke(12'h06C, 16'h0055);
    poke(12'h070, 16'h0777);
    do_reset();
`ifdef MEM_ARB_LOCK_EN
    e.port = 1'b0; e.rdata = 16'h0055; exp_q.push_back(e);
    e.port = 1'b0; e.rdata = 16'h0055; exp_q.push_back(e);
    e.port = 1'b1; e.rdata = 16'h0777; exp_q.push_back(e);
    lock0 = 1'b1;
`else
    e.port = 1'b0; e.rdata = 16'h0055; exp_q.push_back(e);
    e.port = 1'b1; e.rdata = 16'h0777; exp_q.push_back(e);
    e.port = 1'b0; e.rdata = 16'h0777; exp_q.push_back(e);
`endif
    stage = 0; p0_done = 1'b0; p1_done = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h06C;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h070;
    for (int k = 0; k < 30 && !(p0_done && p1_done); k++) begin
      tick();
      if (ack0) begin
        if (stage == 0) begin
          we0 = 1'b1; wdata0 = 16'h0056; stage = 1;
`ifdef MEM_ARB_LOCK_EN
          lock0 = 1'b0;
`endif
        end else begin
          req0 = 1'b0; p0_done = 1'b1;
        end
      end
      if (ack1) begin
        req1 = 1'b0; p1_done = 1'b1;
      end
    end
    chk("rmw_p0_done", {31'd0, p0_done}, 1);
    chk("rmw_p1_done", {31'd0, p1_done}, 1);
    tick();
    do_access(1'b1, 1'b0, 12'h06C, 16'h0000, 16'h0056);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
